// File: rtl/step_sequencer_core.sv
// Multi-track step sequencer engine: a TRACKS x STEPS pattern memory, a
// prescaled tempo timebase, a step pointer with forward / reverse / ping-pong /
// random playback over a programmable loop, and per-track gate/trigger outputs.
// step_tick and trig are valid-only strobes: each is high for exactly one cycle
// per step entry and there is no ready/backpressure path.
module step_sequencer_core #(
  parameter  int STEPS       = 16,
  parameter  int TRACKS      = 4,
  parameter  int PRESCALE    = 100000,
  parameter  int PERIOD_INIT = 125,
  parameter  int MIN_PERIOD  = 20,
  parameter  int MAX_PERIOD  = 1000,
  localparam int SW          = $clog2(STEPS),
  localparam int TW          = (TRACKS > 1) ? $clog2(TRACKS) : 1,
  localparam int PW          = $clog2(MAX_PERIOD + 1)
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              play_toggle,
  input  logic              rewind,
  input  logic              tempo_up,
  input  logic              tempo_down,
  input  logic [1:0]        mode,
  input  logic [SW-1:0]     len_m1,
  input  logic              wr_en,
  input  logic [TW-1:0]     wr_track,
  input  logic [STEPS-1:0]  wr_data,
  output logic              playing,
  output logic [SW-1:0]     step,
  output logic [PW-1:0]     period,
  output logic [TRACKS-1:0] gate,
  output logic [TRACKS-1:0] trig,
  output logic              step_tick
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PING = 2'b10,
    MODE_RAND = 2'b11
  } mode_t;

  // Run state is the only FSM; it is visible on the playing output.
  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_PLAYING = 1'b1
  } run_state_t;

  run_state_t                    state_q, state_d;
  logic [SW-1:0]                 step_q, step_d;
  logic                          dir_up_q, dir_up_d;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [PSW-1:0]                psc_q, psc_d;
  logic [PW-1:0]                 tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]                 period_q, period_d;
  logic [TRACKS-1:0][STEPS-1:0]  pattern_q, pattern_d;
  logic [TRACKS-1:0]             gate_q, gate_d;
  logic [TRACKS-1:0]             trig_q, trig_d;
  logic                          step_tick_q, step_tick_d;

  mode_t         mode_e;
  logic          is_playing;
  logic          tick;
  logic          advance;
  logic          enter;
  logic [SW-1:0] adv_step;
  logic          adv_dir_up;
  logic [SW-1:0] cand;
  logic [15:0]   lfsr_next;

  assign mode_e     = mode_t'(mode);
  assign is_playing = (state_q == ST_PLAYING);
  assign tick       = is_playing && (psc_q == PSW'(PRESCALE - 1));
  assign advance    = tick && (tick_cnt_q >= period_q - PW'(1));
  // Galois right-shift form; the candidate is taken before the shift.
  assign cand       = lfsr_q[SW-1:0];
  assign lfsr_next  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Where the pointer goes on an advance, using mode/len_m1 as sampled now.
  always_comb begin
    adv_step   = step_q;
    adv_dir_up = dir_up_q;
    unique case (mode_e)
      MODE_FWD: adv_step = (step_q >= len_m1) ? '0 : step_q + SW'(1);
      MODE_REV: adv_step = ((step_q == '0) || (step_q > len_m1)) ? len_m1 : step_q - SW'(1);
      MODE_PING: begin
        if (step_q > len_m1) begin
          adv_step   = len_m1;
          adv_dir_up = 1'b0;
        end else if (len_m1 == '0) begin
          adv_step = '0;
        end else if (dir_up_q) begin
          if (step_q == len_m1) begin
            adv_step   = step_q - SW'(1);
            adv_dir_up = 1'b0;
          end else begin
            adv_step = step_q + SW'(1);
          end
        end else begin
          if (step_q == '0) begin
            adv_step   = SW'(1);
            adv_dir_up = 1'b1;
          end else begin
            adv_step = step_q - SW'(1);
          end
        end
      end
      MODE_RAND: adv_step = (cand <= len_m1) ? cand : (cand & len_m1);
      default:   adv_step = step_q;
    endcase
  end

  // Run-state FSM, timebase and pointer; priority play_toggle > rewind > advance.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    dir_up_d   = dir_up_q;
    lfsr_d     = lfsr_q;
    psc_d      = '0;
    tick_cnt_d = '0;
    enter      = 1'b0;
    if (is_playing) begin
      psc_d      = tick ? '0 : psc_q + PSW'(1);
      tick_cnt_d = tick_cnt_q;
      if (tick) tick_cnt_d = advance ? '0 : tick_cnt_q + PW'(1);
    end
    if (play_toggle) begin
      psc_d      = '0;
      tick_cnt_d = '0;
      if (is_playing) begin
        state_d = ST_STOPPED;
      end else begin
        state_d = ST_PLAYING;
        enter   = 1'b1;
      end
    end else if (rewind) begin
      step_d     = (mode_e == MODE_REV) ? len_m1 : '0;
      dir_up_d   = 1'b1;
      psc_d      = '0;
      tick_cnt_d = '0;
      enter      = is_playing;
    end else if (advance) begin
      step_d   = adv_step;
      dir_up_d = adv_dir_up;
      lfsr_d   = lfsr_next;
      enter    = 1'b1;
    end
  end

  // Tempo adjust with saturation; simultaneous up/down cancel.
  always_comb begin
    period_d = period_q;
    if (tempo_up && !tempo_down && (period_q > PW'(MIN_PERIOD))) begin
      period_d = period_q - PW'(1);
    end else if (tempo_down && !tempo_up && (period_q < PW'(MAX_PERIOD))) begin
      period_d = period_q + PW'(1);
    end
  end

  // Pattern row write; rows beyond TRACKS are dropped.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en && (int'(wr_track) < TRACKS)) pattern_d[wr_track] = wr_data;
  end

  // Output staging from the next pointer and the pre-write pattern.
  always_comb begin
    gate_d      = '0;
    trig_d      = '0;
    step_tick_d = enter;
    for (int t = 0; t < TRACKS; t++) begin
      gate_d[t] = (state_d == ST_PLAYING) && pattern_q[t][step_d];
      trig_d[t] = enter && pattern_q[t][step_d];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q     <= ST_STOPPED;
      step_q      <= '0;
      dir_up_q    <= 1'b1;
      lfsr_q      <= 16'hACE1;
      psc_q       <= '0;
      tick_cnt_q  <= '0;
      period_q    <= PW'(PERIOD_INIT);
      pattern_q   <= '0;
      gate_q      <= '0;
      trig_q      <= '0;
      step_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dir_up_q    <= dir_up_d;
      lfsr_q      <= lfsr_d;
      psc_q       <= psc_d;
      tick_cnt_q  <= tick_cnt_d;
      period_q    <= period_d;
      pattern_q   <= pattern_d;
      gate_q      <= gate_d;
      trig_q      <= trig_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign playing   = is_playing;
  assign step      = step_q;
  assign period    = period_q;
  assign gate      = gate_q;
  assign trig      = trig_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_step_sequencer_core.sv
// Bench for step_sequencer_core: driver tasks push expected step entries
// (edge number, step, trigger column) into exp_q; a negedge monitor pops and
// compares whenever step_tick is seen, and flags entries that never arrive.
`timescale 1ns/1ps
module tb_step_sequencer_core;

  localparam int STEPS       = 16;
  localparam int TRACKS      = 4;
  localparam int PRESCALE    = 2;
  localparam int PERIOD_INIT = 4;
  localparam int MIN_PERIOD  = 2;
  localparam int MAX_PERIOD  = 6;
  localparam int SW          = 4;
  localparam int TW          = 2;
  localparam int PW          = 3;
  localparam int W           = 40;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic              play_toggle = 1'b0;
  logic              rewind      = 1'b0;
  logic              tempo_up    = 1'b0;
  logic              tempo_down  = 1'b0;
  logic [1:0]        mode        = 2'b00;
  logic [SW-1:0]     len_m1      = 4'd15;
  logic              wr_en       = 1'b0;
  logic [TW-1:0]     wr_track    = '0;
  logic [STEPS-1:0]  wr_data     = '0;
  logic              playing;
  logic [SW-1:0]     step;
  logic [PW-1:0]     period;
  logic [TRACKS-1:0] gate;
  logic [TRACKS-1:0] trig;
  logic              step_tick;

  step_sequencer_core #(
    .STEPS(STEPS), .TRACKS(TRACKS), .PRESCALE(PRESCALE),
    .PERIOD_INIT(PERIOD_INIT), .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n),
    .play_toggle(play_toggle), .rewind(rewind),
    .tempo_up(tempo_up), .tempo_down(tempo_down),
    .mode(mode), .len_m1(len_m1),
    .wr_en(wr_en), .wr_track(wr_track), .wr_data(wr_data),
    .playing(playing), .step(step), .period(period),
    .gate(gate), .trig(trig), .step_tick(step_tick)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_step;
  int               m_period;
  bit               m_dir_up;
  bit               m_playing;
  logic [15:0]      m_lfsr;
  logic [STEPS-1:0] m_pat[TRACKS];
  int               m_next_adv;

  function automatic void model_reset();
    m_step    = 0;
    m_period  = PERIOD_INIT;
    m_dir_up  = 1'b1;
    m_playing = 1'b0;
    m_lfsr    = 16'hACE1;
    for (int t = 0; t < TRACKS; t++) m_pat[t] = '0;
  endfunction

  function automatic logic [TRACKS-1:0] col(input int s);
    logic [TRACKS-1:0] r;
    for (int t = 0; t < TRACKS; t++) r[t] = m_pat[t][s];
    return r;
  endfunction

  // One advance, straight from the playback rules.
  function automatic void model_advance();
    int l = int'(len_m1);
    int s = m_step;
    int c;
    case (mode)
      2'b00: s = (s >= l) ? 0 : s + 1;
      2'b01: s = (s == 0 || s > l) ? l : s - 1;
      2'b10: begin
        if (s > l) begin
          s = l;
          m_dir_up = 1'b0;
        end else if (l == 0) begin
          s = 0;
        end else begin
          if (m_dir_up && s == l) m_dir_up = 1'b0;
          else if (!m_dir_up && s == 0) m_dir_up = 1'b1;
          s = m_dir_up ? s + 1 : s - 1;
        end
      end
      default: begin
        c = int'(m_lfsr) % STEPS;
        s = (c <= l) ? c : (c & l);
      end
    endcase
    m_step = s;
    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else           m_lfsr = m_lfsr >> 1;
  endfunction

  function automatic void push_exp(input int when, input int s);
    logic [31:0] w = when;
    logic [3:0]  sv = s[3:0];
    exp_q.push_back({w, sv, col(s)});
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (step_tick) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_step_tick: got step %0d at cycle %0d, required no entry", step, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("entry_cycle", cyc, mon_e[39:8]);
          check("entry_step", {28'd0, step}, {28'd0, mon_e[7:4]});
          check("entry_trig", {28'd0, trig}, {28'd0, mon_e[3:0]});
          check("entry_gate", {28'd0, gate}, {28'd0, mon_e[3:0]});
        end
      end else begin
        if (exp_q.size() != 0 && int'(exp_q[0][39:8]) <= cyc) begin
          mon_e = exp_q.pop_front();
          n_checks++;
          n_errors++;
          $display("FAIL missed_step_tick: got none at cycle %0d, required step %0d", cyc, mon_e[7:4]);
        end
        if (trig != '0) begin
          n_checks++;
          n_errors++;
          $display("FAIL trig_without_tick: got 0x%0h, required 0x0 (cycle %0d)", trig, cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_row(input int t, input logic [STEPS-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_track = t[TW-1:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_pat[t] = d;
  endtask

  task automatic tempo(input bit up, input bit down);
    @(negedge clk);
    tempo_up = up; tempo_down = down;
    @(negedge clk);
    tempo_up = 1'b0; tempo_down = 1'b0;
    if (up && !down && m_period > MIN_PERIOD) m_period--;
    else if (down && !up && m_period < MAX_PERIOD) m_period++;
  endtask

  task automatic start_play();
    int n;
    @(negedge clk);
    play_toggle = 1'b1;
    n = cyc + 1;
    m_playing = 1'b1;
    push_exp(n, m_step);
    m_next_adv = n + m_period * PRESCALE;
    @(negedge clk);
    play_toggle = 1'b0;
  endtask

  task automatic stop_play();
    @(negedge clk);
    play_toggle = 1'b1;
    m_playing = 1'b0;
    @(negedge clk);
    play_toggle = 1'b0;
    check("stop_playing", {31'd0, playing}, 32'd0);
    check("stop_gate", {28'd0, gate}, 32'd0);
    check("stop_step_hold", {28'd0, step}, m_step);
  endtask

  task automatic run_adv(input int n);
    int last = cyc;
    for (int i = 0; i < n; i++) begin
      model_advance();
      push_exp(m_next_adv, m_step);
      last = m_next_adv;
      m_next_adv = m_next_adv + m_period * PRESCALE;
    end
    while (cyc < last) @(negedge clk);
  endtask

  task automatic do_rewind();
    int r;
    @(negedge clk);
    rewind = 1'b1;
    r = cyc + 1;
    m_step   = (mode == 2'b01) ? int'(len_m1) : 0;
    m_dir_up = 1'b1;
    if (m_playing) begin
      push_exp(r, m_step);
      m_next_adv = r + m_period * PRESCALE;
    end
    @(negedge clk);
    rewind = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TRACKS-1:0] old_col;
    logic [STEPS-1:0]  d;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_step", {28'd0, step}, 32'd0);
    check("rst_period", {29'd0, period}, PERIOD_INIT);
    check("rst_gate", {28'd0, gate}, 32'd0);
    check("rst_trig", {28'd0, trig}, 32'd0);
    check("rst_step_tick", {31'd0, step_tick}, 32'd0);

    // Forward over the full pattern.
    mode = 2'b00; len_m1 = 4'd15;
    write_row(0, 16'h00FF);
    for (int t = 1; t < TRACKS; t++) write_row(t, 16'($urandom_range(0, 16'hFFFF)));
    start_play();
    run_adv(16);
    stop_play();

    // Reverse over a 4-step loop: 3,2,1,0,3.
    mode = 2'b01; len_m1 = 4'd3;
    start_play();
    run_adv(5);
    stop_play();
    check("rev_end_step", {28'd0, step}, 32'd3);

    // Ping-pong: 1,2,3,2,1,0,1.
    mode = 2'b10;
    do_rewind();
    check("rewind_stopped_step", {28'd0, step}, 32'd0);
    start_play();
    run_adv(7);
    stop_play();
    check("ping_end_step", {28'd0, step}, 32'd1);

    // Random over a 6-step loop.
    mode = 2'b11; len_m1 = 4'd5;
    start_play();
    run_adv(64);
    stop_play();
    check("rand_in_range", {31'd0, (step <= 4'd5)}, 32'd1);

    // Tempo saturation and cancel.
    mode = 2'b00; len_m1 = 4'd15;
    repeat (3) tempo(1'b1, 1'b0);
    check("tempo_min_sat", {29'd0, period}, MIN_PERIOD);
    start_play();
    run_adv(4);
    stop_play();
    repeat (6) tempo(1'b0, 1'b1);
    check("tempo_max_sat", {29'd0, period}, MAX_PERIOD);
    tempo(1'b1, 1'b0);
    tempo(1'b1, 1'b1);
    check("tempo_both_hold", {29'd0, period}, 32'd5);
    tempo(1'b1, 1'b0);
    check("tempo_back_init", {29'd0, period}, 32'd4);

    // Stop at 9, restart re-enters 9, rewind while playing, len shrink.
    do_rewind();
    start_play();
    run_adv(9);
    stop_play();
    check("stop_at_9", {28'd0, step}, 32'd9);
    start_play();
    run_adv(1);
    do_rewind();
    run_adv(10);
    old_col = col(m_step);
    d = ~m_pat[1];
    write_row(1, d);
    check("gate_old_row", {28'd0, gate}, {28'd0, old_col});
    @(negedge clk);
    check("gate_new_row", {28'd0, gate}, {28'd0, col(m_step)});
    len_m1 = 4'd4;
    @(negedge clk);
    check("len_change_no_move", {28'd0, step}, 32'd10);
    run_adv(1);
    check("len_shrink_wrap", {28'd0, step}, 32'd0);
    stop_play();

    // Asynchronous reset mid-step at step 7.
    len_m1 = 4'd15;
    do_rewind();
    start_play();
    run_adv(7);
    repeat (3) @(negedge clk);
    check("pre_reset_drained", exp_q.size(), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_playing", {31'd0, playing}, 32'd0);
    check("async_rst_step", {28'd0, step}, 32'd0);
    check("async_rst_period", {29'd0, period}, PERIOD_INIT);
    check("async_rst_gate", {28'd0, gate}, 32'd0);
    check("async_rst_trig", {28'd0, trig}, 32'd0);
    check("async_rst_tick", {31'd0, step_tick}, 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_playing", {31'd0, playing}, 32'd0);
    check("post_rst_period", {29'd0, period}, PERIOD_INIT);
    start_play();
    run_adv(2);
    stop_play();

    // Randomised sessions.
    for (int r = 0; r < 8; r++) begin
      mode   = 2'($urandom_range(0, 3));
      len_m1 = 4'($urandom_range(0, 15));
      write_row(int'($urandom_range(0, TRACKS - 1)), 16'($urandom_range(0, 16'hFFFF)));
      repeat ($urandom_range(0, 3)) tempo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rand_period", {29'd0, period}, m_period);
      start_play();
      run_adv(int'($urandom_range(2, 8)));
      if ($urandom_range(0, 1) == 1) begin
        do_rewind();
        run_adv(int'($urandom_range(1, 4)));
      end
      stop_play();
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    n_errors++;
    $display("FAIL timeout: got no completion by cycle %0d, required completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
